// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared defaults, FSM state encoding and index-width helper for the sprite ROM arbiter.
package sprite_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LEN_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width needed to index n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-facing burst request and response bus of the sprite ROM arbiter.
interface sprite_req_if
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_last;

  modport master (
    output req_valid, req_addr, req_len,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr.sv
// Round-robin picker: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Arbitrates burst reads of a shared sprite ROM among several requesters and
// routes the returning words, two cycles after issue, to the burst owner.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  sprite_req_if.slave       bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy
);

  localparam int PTR_W = idx_width(NUM_REQ);

  arb_state_t         state;
  logic [PTR_W-1:0]   ptr;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W-1:0]   remain;
  logic [PTR_W-1:0]   owner;
  logic               p1_valid;
  logic               p1_last;
  logic [PTR_W-1:0]   p1_owner;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               rsp_last_q;
  logic [DATA_W-1:0]  rsp_data_q;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   sel_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [NUM_REQ-1:0] p1_onehot;
  logic               can_grant;
  logic               issue;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    sel_idx   = '0;
    sel_addr  = '0;
    sel_len   = '0;
    p1_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx  = PTR_W'(i);
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = bus.req_len[i*LEN_W +: LEN_W];
      end
      p1_onehot[i] = p1_valid && (p1_owner == PTR_W'(i));
    end
  end

  // Reset is folded in so every output reads zero the moment reset_n drops.
  assign can_grant      = reset_n && !hold && (state == IDLE) && (|grant);
  assign issue          = reset_n && !hold && (state == BURST);
  assign bus.req_ready  = can_grant ? grant : '0;
  assign mem_address    = cur_addr;
  assign mem_chipselect = issue;
  assign mem_clken      = reset_n & ~hold;
  assign bus.rsp_valid  = rsp_valid_q & {NUM_REQ{~hold}};
  assign bus.rsp_last   = rsp_last_q & ~hold;
  assign bus.rsp_data   = rsp_data_q;
  assign busy           = (state == BURST) || p1_valid || (|rsp_valid_q);

  // Burst FSM plus the two-stage response pipeline; hold freezes all of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cur_addr    <= '0;
      remain      <= '0;
      owner       <= '0;
      p1_valid    <= 1'b0;
      p1_last     <= 1'b0;
      p1_owner    <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else if (!hold) begin
      p1_valid    <= issue;
      p1_last     <= issue && (remain == '0);
      p1_owner    <= owner;
      rsp_valid_q <= p1_onehot;
      rsp_last_q  <= p1_valid && p1_last;
      if (p1_valid) rsp_data_q <= mem_readdata;

      case (state)
        IDLE: begin
          if (|grant) begin
            cur_addr <= sel_addr;
            remain   <= sel_len;
            owner    <= sel_idx;
            ptr      <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
            state    <= BURST;
          end
        end
        BURST: begin
          if (remain == '0) begin
            state <= IDLE;
          end else begin
            remain   <= remain - LEN_W'(1);
            cur_addr <= cur_addr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed bursts push expected issues
// and responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              hold;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic              busy;

  sprite_req_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hold           (hold),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // Synchronous ROM: data for an address appears the cycle after it.
  always @(posedge clk) if (mem_clken) mem_readdata <= mem_word(mem_address);

  typedef struct { logic [7:0] addr; int cyc; } issue_t;
  typedef struct { logic [1:0] valid; logic [15:0] data; logic last; int cyc; } rsp_t;

  issue_t issue_q[$];
  rsp_t   rsp_q[$];
  int     tests = 0;
  int     fails = 0;
  bit     timed = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushBurst(input int owner, input logic [7:0] addr, input int len, input int gc);
    for (int k = 0; k <= len; k++) begin
      issue_q.push_back('{addr: 8'(addr + k), cyc: gc + 1 + k});
      rsp_q.push_back('{valid: 2'(1 << owner), data: mem_word(8'(addr + k)),
                        last: (k == len), cyc: gc + 3 + k});
    end
  endtask

  issue_t e;
  rsp_t   r;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (hold) begin
        checkOutput("hold_clken", 32'(mem_clken), 0);
        checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("hold_chipselect", 32'(mem_chipselect), 0);
        checkOutput("hold_req_ready", 32'(bus.req_ready), 0);
      end
      if (mem_chipselect) begin
        checkOutput("issue_expected", 32'(issue_q.size() != 0), 1);
        if (issue_q.size() != 0) begin
          e = issue_q.pop_front();
          checkOutput("mem_address", 32'(mem_address), 32'(e.addr));
          if (timed) checkOutput("issue_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.rsp_valid != '0) begin
        checkOutput("rsp_expected", 32'(rsp_q.size() != 0), 1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(r.valid));
          checkOutput("rsp_data", 32'(bus.rsp_data), 32'(r.data));
          checkOutput("rsp_last", 32'(bus.rsp_last), 32'(r.last));
          if (timed) checkOutput("rsp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  // Raise the masked requests, follow grants in the expected order, then drain.
  task automatic applyStimulus(input logic [1:0] mask, input logic [7:0] a0, input logic [3:0] l0,
                               input logic [7:0] a1, input logic [3:0] l1, input int first);
    logic [1:0] pend;
    int start;
    int n;
    int budget;
    int g;
    pend   = mask;
    n      = 0;
    budget = 0;
    @(posedge clk); #1;
    bus.req_addr  = {a1, a0};
    bus.req_len   = {l1, l0};
    bus.req_valid = mask;
    start = cyc;
    while (pend != 2'b00 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (bus.req_ready != 2'b00) begin
        g = bus.req_ready[1] ? 1 : 0;
        checkOutput("grant_order", 32'(g), 32'((n == 0) ? first : 1 - first));
        checkOutput("grant_pending", 32'(pend[g]), 1);
        if (n == 0) checkOutput("grant_latency", 32'(cyc), 32'(start));
        pushBurst(g, g ? a1 : a0, g ? int'(l1) : int'(l0), cyc);
        pend[g] = 1'b0;
        n++;
        @(posedge clk); #1;
        bus.req_valid = pend;
      end
    end
    checkOutput("grant_timeout", 32'(pend), 0);
    bus.req_valid = 2'b00;
    budget = 0;
    @(negedge clk);
    while (busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("busy_drain", 32'(busy), 0);
    checkOutput("rsp_queue_empty", 32'(rsp_q.size()), 0);
    checkOutput("issue_queue_empty", 32'(issue_q.size()), 0);
  endtask

  int quiet;

  initial begin
    reset_n       = 1'b0;
    hold          = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;

    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    #1;
    checkOutput("reset_req_ready", 32'(bus.req_ready), 0);
    checkOutput("reset_chipselect", 32'(mem_chipselect), 0);
    checkOutput("reset_clken", 32'(mem_clken), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single request, then address wrap, then two single-word bursts.
    applyStimulus(2'b01, 8'h10, 4'd3, 8'h00, 4'd0, 0);
    applyStimulus(2'b01, 8'hFE, 4'd3, 8'h00, 4'd0, 0);
    applyStimulus(2'b10, 8'h00, 4'd0, 8'h33, 4'd0, 1);
    applyStimulus(2'b10, 8'h00, 4'd0, 8'h34, 4'd0, 1);

    // Three-cycle hold in the middle of a 16-word burst.
    timed = 1'b0;
    fork
      applyStimulus(2'b10, 8'h00, 4'd0, 8'h80, 4'd15, 1);
      begin
        repeat (7) @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
      end
    join
    timed = 1'b1;

    // Reset after two of eight words have been issued.
    @(posedge clk); #1;
    bus.req_addr  = {8'h00, 8'h40};
    bus.req_len   = {4'd0, 4'd7};
    bus.req_valid = 2'b01;
    @(negedge clk);
    checkOutput("mid_reset_grant", 32'(bus.req_ready), 32'h1);
    pushBurst(0, 8'h40, 7, cyc);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    issue_q.delete();
    rsp_q.delete();
    #1;
    checkOutput("mid_reset_chipselect", 32'(mem_chipselect), 0);
    checkOutput("mid_reset_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("mid_reset_rsp_last", 32'(bus.rsp_last), 0);
    checkOutput("mid_reset_rsp_data", 32'(bus.rsp_data), 0);
    checkOutput("mid_reset_address", 32'(mem_address), 0);
    checkOutput("mid_reset_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00 || mem_chipselect) quiet++;
    end
    checkOutput("post_reset_quiet", 32'(quiet), 0);

    // Pointer restarts at 0: four bursts alternate 0,1,0,1.
    applyStimulus(2'b11, 8'h20, 4'd2, 8'hA0, 4'd1, 0);
    applyStimulus(2'b11, 8'h30, 4'd0, 8'hB0, 4'd4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters.
REQ-002 SHALL have parameter ADDR_W, default 8: sprite memory word address width (256 words).
REQ-003 SHALL have parameter DATA_W, default 16: sprite memory word width.
REQ-004 SHALL have parameter LEN_W, default 4: burst length field width, encoded as words minus one.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester burst request; held until req_ready.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  per-requester burst start address; requester i uses slice i.
REQ-009 req_len  input  NUM_REQ*LEN_W  per-requester burst length minus one.
REQ-010 req_ready  output  NUM_REQ  one-cycle accept pulse, one-hot or zero.
REQ-011 hold  input  1  pipeline freeze.
REQ-012 mem_address  output  ADDR_W  memory port address.
REQ-013 mem_chipselect  output  1  memory read strobe.
REQ-014 mem_clken  output  1  memory clock enable; equals ~hold.
REQ-015 mem_readdata  input  DATA_W  memory data, valid one cycle after its address.
REQ-016 rsp_valid  output  NUM_REQ  per-requester response strobe, one-hot or zero.
REQ-017 rsp_data  output  DATA_W  shared response word, qualified by rsp_valid.
REQ-018 rsp_last  output  1  marks the final word of a burst.
REQ-019 busy  output  1  high while the FSM is in BURST or any response is outstanding.

Function
REQ-020 SHALL implement FSM states IDLE and BURST.
REQ-021 IDLE, any req_valid, hold=0: grant the first requester at or after the round-robin pointer (modulo NUM_REQ).
REQ-022 On grant: pulse req_ready[g] that cycle (combinational); latch addr, len, owner g; set pointer to (g+1) mod NUM_REQ; go to BURST.
REQ-023 IDLE issues no memory read: mem_chipselect=0.
REQ-024 BURST: drive mem_address=cur_addr and mem_chipselect=1 each cycle; cur_addr increments modulo 2^ADDR_W (0xFF wraps to 0x00); remaining count decrements.
REQ-025 After issuing word req_len+1, return to IDLE; a new grant is possible in that IDLE cycle.
REQ-026 req_valid during BURST SHALL not be acknowledged; it SHALL be arbitered at the next IDLE.
REQ-027 Response timing: a word issued at cycle t SHALL appear registered at t+2: rsp_data = mem_readdata captured at t+1, with rsp_valid[owner]=1.
REQ-028 For a grant at cycle A: first issue at A+1, first response at A+3, last response at A+req_len+3 with rsp_last=1.
REQ-029 No response backpressure exists; requesters SHALL accept rsp data every valid cycle.
REQ-030 hold=1 SHALL freeze FSM, counters, pointer and pipeline.
REQ-031 Under hold=1: req_ready=0, rsp_valid=0, mem_chipselect=0, mem_clken=0; when hold falls, resume exactly where frozen with no lost or duplicated word.
REQ-032 req_len=0 SHALL give a single-word burst with rsp_last on that word.
REQ-033 A requester dropping req_valid before grant SHALL receive no grant and no responses.

Reset
REQ-034 reset_n low SHALL immediately clear: state=IDLE, pointer=0, all outputs 0, response pipeline emptied.
REQ-035 Reset mid-burst SHALL discard outstanding words; no rsp_valid SHALL occur after release until a new grant.

Structure
REQ-036 Package sprite_arb_pkg SHALL hold ADDR_W/DATA_W/LEN_W defaults and the FSM state enum.
REQ-037 Round-robin selection SHALL be a sub-module, rr_arbiter: inputs request vector and pointer; output one-hot grant.

Verification
REQ-038 Single request: req0 addr 0x10, len 3 -> mem_address 0x10..0x13 on A+1..A+4; rsp_valid[0] A+3..A+6; rsp_last at A+6.
REQ-039 Simultaneous requests: req0 and req1 both valid, pointer 0 -> req0 granted first, then req1 at the next IDLE; pointer alternates over 4 bursts.
REQ-040 Wrap: addr 0xFE, len 3 -> addresses 0xFE, 0xFF, 0x00, 0x01; data matches the memory model.
REQ-041 Hold: hold high for 3 cycles mid-burst -> mem_clken=0 and rsp_valid=0 during hold; all 16 words of a len-15 burst arrive in order, once each.
REQ-042 Reset mid-burst: reset_n low after 2 of 8 words -> outputs 0 at once; no rsp_valid after release until a new grant.
REQ-043 len=0 back-to-back: req1 len 0 twice -> two single-word responses, each with rsp_last=1.
